// File: rtl/button_conditioner.sv
// Four-lane push-button conditioner: 2-flop synchroniser, counter debounce, press/release pulses.
// Define BTN_AUTOREPEAT_EN to add held-button auto-repeat on btn_press.
module button_conditioner #(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 2500000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [0:0]    ST_STABLE = 1'b0;
  localparam logic [0:0]    ST_COUNT  = 1'b1;

  logic [NUM_BTN-1:0] sync0_q, sync1_q;
  logic [NUM_BTN-1:0] state_q, state_d;
  logic [CW-1:0]      cnt_q [NUM_BTN];
  logic [CW-1:0]      cnt_d [NUM_BTN];
  logic [NUM_BTN-1:0] level_q, level_d;
  logic [NUM_BTN-1:0] press_q, press_d;
  logic [NUM_BTN-1:0] release_q, release_d;
  logic [NUM_BTN-1:0] flip;

  // Debounce lanes: any sample matching the current level is a bounce and restarts the count.
  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      flip[i]    = 1'b0;
      if (sync1_q[i] == level_q[i]) begin
        state_d[i] = ST_STABLE;
        cnt_d[i]   = '0;
      end else if (state_q[i] == ST_STABLE) begin
        if (DEBOUNCE_CYCLES == 1) begin
          flip[i] = 1'b1;
        end else begin
          state_d[i] = ST_COUNT;
          cnt_d[i]   = CW'(1);
        end
      end else if (cnt_q[i] == CNT_LAST) begin
        flip[i]    = 1'b1;
        state_d[i] = ST_STABLE;
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  assign level_d   = level_q ^ flip;
  assign release_d = flip & level_q;

`ifdef BTN_AUTOREPEAT_EN
  localparam int            HMAX        = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int            HW          = $clog2(HMAX + 1);
  localparam logic [HW-1:0] DELAY_LAST  = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] PERIOD_LAST = HW'(REPEAT_PERIOD - 1);

  logic [HW-1:0]      hold_q [NUM_BTN];
  logic [HW-1:0]      hold_d [NUM_BTN];
  logic [NUM_BTN-1:0] rep_q, rep_d, rep_fire;

  // rep_q marks that the initial delay has elapsed, so later pulses use the shorter period.
  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      hold_d[i]   = hold_q[i];
      rep_d[i]    = rep_q[i];
      rep_fire[i] = 1'b0;
      if (!level_q[i] || flip[i]) begin
        hold_d[i] = '0;
        rep_d[i]  = 1'b0;
      end else if ((!rep_q[i] && hold_q[i] == DELAY_LAST) ||
                   ( rep_q[i] && hold_q[i] == PERIOD_LAST)) begin
        rep_fire[i] = 1'b1;
        hold_d[i]   = '0;
        rep_d[i]    = 1'b1;
      end else begin
        hold_d[i] = hold_q[i] + HW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rep_q <= '0;
      for (int i = 0; i < NUM_BTN; i++) hold_q[i] <= '0;
    end else begin
      rep_q <= rep_d;
      for (int i = 0; i < NUM_BTN; i++) hold_q[i] <= hold_d[i];
    end
  end

  assign press_d = (flip & ~level_q) | rep_fire;
`else
  assign press_d = flip & ~level_q;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      sync0_q   <= '0;
      sync1_q   <= '0;
      state_q   <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= '0;
    end else begin
      sync0_q   <= btn_in;
      sync1_q   <= sync0_q;
      state_q   <= state_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < NUM_BTN; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random stimulus against a sample-window model.
module tb_button_conditioner;

  localparam int NB = 4;
  localparam int DC = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [NB-1:0] btn_in = '0;
  logic [NB-1:0] btn_level, btn_press, btn_release;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  button_conditioner #(
    .NUM_BTN(NB), .DEBOUNCE_CYCLES(DC), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clock(clock), .reset(reset), .btn_in(btn_in),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
  );

  // Model: a lane flips when the DC raw samples taken 2..DC+1 edges ago all differ from its level.
  logic [NB-1:0] hist [0:DC];
  logic [NB-1:0] m_level = '0, m_press = '0, m_rel = '0;
  int            cyc = 0;
  int            press_cyc [NB];

  function automatic logic [NB-1:0] window_flip();
    logic [NB-1:0] f;
    for (int i = 0; i < NB; i++) begin
      f[i] = 1'b1;
      for (int k = 1; k <= DC; k++)
        if (hist[k][i] == m_level[i]) f[i] = 1'b0;
    end
    return f;
  endfunction

  function automatic logic [NB-1:0] repeat_due(input logic [NB-1:0] f);
    logic [NB-1:0] r;
    r = '0;
`ifdef BTN_AUTOREPEAT_EN
    for (int i = 0; i < NB; i++) begin
      int d;
      d = cyc - press_cyc[i];
      if (m_level[i] && !f[i] && (d == RD || (d > RD && (d - RD) % RP == 0))) r[i] = 1'b1;
    end
`endif
    return r;
  endfunction

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (reset) begin
      for (int k = 0; k <= DC; k++) hist[k] <= '0;
      m_level <= '0;
      m_press <= '0;
      m_rel   <= '0;
    end else begin
      hist[0] <= btn_in;
      for (int k = 1; k <= DC; k++) hist[k] <= hist[k-1];
      m_level <= m_level ^ window_flip();
      m_press <= (window_flip() & ~m_level) | repeat_due(window_flip());
      m_rel   <= window_flip() & m_level;
      for (int i = 0; i < NB; i++)
        if (window_flip()[i] && !m_level[i]) press_cyc[i] <= cyc;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    btn_in = '0;
    repeat (10) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    btn_in = 4'b1011;
    repeat (3) tick();
    n_tests++;
    if (btn_level !== '0 || btn_press !== '0 || btn_release !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got lvl=%b prs=%b rel=%b, need all 0", btn_level, btn_press, btn_release);
    end
    btn_in = '0;
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_tests++;
      if (btn_level !== '0 || btn_press !== '0 || btn_release !== '0) begin
        n_fail++;
        $display("FAIL reset_idle k=%0d: got lvl=%b prs=%b rel=%b, need all 0", k, btn_level, btn_press, btn_release);
      end
    end
  endtask

  task automatic test_clean_press();
    btn_in = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      logic [NB-1:0] el, ep;
      tick();
      el = (k >= 5) ? 4'b0001 : 4'b0000;
      ep = (k == 5) ? 4'b0001 : 4'b0000;
      n_tests++;
      if (btn_level !== el || btn_press !== ep || btn_release !== '0) begin
        n_fail++;
        $display("FAIL clean_press edge %0d: got lvl=%b prs=%b rel=%b, need lvl=%b prs=%b rel=0000",
                 k, btn_level, btn_press, btn_release, el, ep);
      end
    end
    settle();
  endtask

  task automatic test_bounce();
    logic [15:0] pat;
    pat = 16'b0000_0000_0011_0011;
    for (int k = 0; k < 16; k++) begin
      btn_in = {2'b00, pat[k], 1'b0};
      tick();
      n_tests++;
      if (btn_level !== '0 || btn_press !== '0 || btn_release !== '0) begin
        n_fail++;
        $display("FAIL bounce step %0d: got lvl=%b prs=%b rel=%b, need all 0", k, btn_level, btn_press, btn_release);
      end
    end
    settle();
  endtask

  task automatic test_release();
    btn_in = 4'b0100;
    repeat (8) tick();
    n_tests++;
    if (btn_level !== 4'b0100) begin
      n_fail++;
      $display("FAIL release_setup: got lvl=%b, need 0100", btn_level);
    end
    btn_in = '0;
    for (int k = 0; k < 8; k++) begin
      logic [NB-1:0] el, er;
      tick();
      el = (k >= 5) ? 4'b0000 : 4'b0100;
      er = (k == 5) ? 4'b0100 : 4'b0000;
      n_tests++;
      if (btn_level !== el || btn_release !== er || btn_press !== '0) begin
        n_fail++;
        $display("FAIL release edge %0d: got lvl=%b prs=%b rel=%b, need lvl=%b prs=0000 rel=%b",
                 k, btn_level, btn_press, btn_release, el, er);
      end
    end
    settle();
  endtask

  task automatic test_simultaneous();
    btn_in = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      logic [NB-1:0] el, ep;
      tick();
      el = (k >= 5) ? 4'b1111 : 4'b0000;
      ep = (k == 5) ? 4'b1111 : 4'b0000;
      n_tests++;
      if (btn_level !== el || btn_press !== ep || btn_release !== '0) begin
        n_fail++;
        $display("FAIL simul_press edge %0d: got lvl=%b prs=%b rel=%b, need lvl=%b prs=%b",
                 k, btn_level, btn_press, btn_release, el, ep);
      end
    end
    btn_in = '0;
    for (int k = 0; k < 8; k++) begin
      logic [NB-1:0] er;
      tick();
      er = (k == 5) ? 4'b1111 : 4'b0000;
      n_tests++;
      if (btn_release !== er || btn_press !== '0) begin
        n_fail++;
        $display("FAIL simul_release edge %0d: got prs=%b rel=%b, need prs=0000 rel=%b", k, btn_press, btn_release, er);
      end
    end
    settle();
  endtask

  task automatic test_reset_mid_hold();
    btn_in = 4'b1000;
    repeat (8) tick();
    n_tests++;
    if (btn_level !== 4'b1000) begin
      n_fail++;
      $display("FAIL midhold_setup: got lvl=%b, need 1000", btn_level);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_tests++;
    if (btn_level !== '0 || btn_press !== '0 || btn_release !== '0) begin
      n_fail++;
      $display("FAIL midhold_reset: got lvl=%b prs=%b rel=%b, need all 0", btn_level, btn_press, btn_release);
    end
    for (int k = 0; k < 8; k++) begin
      logic [NB-1:0] el, ep;
      tick();
      el = (k >= 5) ? 4'b1000 : 4'b0000;
      ep = (k == 5) ? 4'b1000 : 4'b0000;
      n_tests++;
      if (btn_level !== el || btn_press !== ep || btn_release !== '0) begin
        n_fail++;
        $display("FAIL midhold_repress edge %0d: got lvl=%b prs=%b rel=%b, need lvl=%b prs=%b rel=0000",
                 k, btn_level, btn_press, btn_release, el, ep);
      end
    end
    settle();
  endtask

`ifdef BTN_AUTOREPEAT_EN
  task automatic test_autorepeat();
    btn_in = 4'b0001;
    for (int k = 0; k < 30; k++) begin
      logic [NB-1:0] ep;
      tick();
      ep = (k == 5 || (k >= 15 && (k - 15) % 3 == 0)) ? 4'b0001 : 4'b0000;
      n_tests++;
      if (btn_press !== ep) begin
        n_fail++;
        $display("FAIL autorepeat edge %0d: got prs=%b, need %b", k, btn_press, ep);
      end
    end
    btn_in = '0;
    for (int k = 0; k < 15; k++) begin
      tick();
      n_tests++;
      if (btn_press !== '0) begin
        n_fail++;
        $display("FAIL autorepeat_after_release edge %0d: got prs=%b, need 0000", k, btn_press);
      end
    end
    settle();
  endtask
`endif

  task automatic test_random();
    int remain [NB];
    for (int i = 0; i < NB; i++) remain[i] = $urandom_range(1, 24);
    for (int t = 0; t < 1500; t++) begin
      for (int i = 0; i < NB; i++) begin
        remain[i]--;
        if (remain[i] <= 0) begin
          btn_in[i] = ~btn_in[i];
          remain[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(1, 40);
        end
      end
      reset = ($urandom_range(0, 199) == 0);
      tick();
      n_tests++;
      if (btn_level !== m_level || btn_press !== m_press || btn_release !== m_rel) begin
        n_fail++;
        $display("FAIL random t=%0d: got lvl=%b prs=%b rel=%b, need lvl=%b prs=%b rel=%b",
                 t, btn_level, btn_press, btn_release, m_level, m_press, m_rel);
      end
      n_tests++;
      if ((btn_press & btn_release) !== '0) begin
        n_fail++;
        $display("FAIL random_overlap t=%0d: got prs&rel=%b, need 0000", t, btn_press & btn_release);
      end
    end
    reset = 1'b0;
    settle();
  endtask

  initial begin
    for (int i = 0; i < NB; i++) press_cyc[i] = 0;
    #1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_simultaneous();
    test_reset_mid_hold();
`ifdef BTN_AUTOREPEAT_EN
    test_autorepeat();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Conditions the four raw Basys3 push buttons (btnU, btnD, btnL, btnR) before they reach ui_in[3:0] of the pong core.
- Per button: 2-flop synchroniser, counter-based debounce, registered press/release edge pulses.
- Sits directly upstream of the user project inside the FPGA top level; the ASIC flow does not use it.
- Every button is an independent lane; no cross-lane interaction.

Parameters:
- NUM_BTN, 4, number of independent button lanes.
- DEBOUNCE_CYCLES, 250000, consecutive cycles the synchronised input must differ from btn_level before btn_level flips. Must be >= 1.
- REPEAT_DELAY, 12500000, cycles held before the first auto-repeat pulse. Used only with BTN_AUTOREPEAT_EN.
- REPEAT_PERIOD, 2500000, cycles between later auto-repeat pulses. Used only with BTN_AUTOREPEAT_EN.

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- btn_in  input  NUM_BTN  raw asynchronous button pins; bit0=U, bit1=D, bit2=L, bit3=R.
- btn_level  output  NUM_BTN  debounced level, registered; drives ui_in[3:0].
- btn_press  output  NUM_BTN  one-cycle registered pulse on a debounced 0->1 change (and on auto-repeat, if enabled).
- btn_release  output  NUM_BTN  one-cycle registered pulse on a debounced 1->0 change.

Behaviour:
- Reset:
  - Applies only on a clock edge with reset=1.
  - Clears sync flops, counters, lane state, btn_level, btn_press and btn_release to 0.
  - All outputs are 0 in the cycle after the reset edge.
- Synchroniser:
  - sync0 <= btn_in[i]; s <= sync0.
  - No logic reads sync0 directly.
- Lane state machine, two states:
  - STABLE: cnt = 0. If s == btn_level, stay. If s != btn_level, go to COUNTING with cnt = 1. If DEBOUNCE_CYCLES == 1, flip immediately instead.
  - COUNTING, s == btn_level (bounce): return to STABLE, cnt = 0, no output change.
  - COUNTING, s != btn_level and cnt == DEBOUNCE_CYCLES-1: flip btn_level, pulse press or release, return to STABLE, cnt = 0.
  - COUNTING, otherwise: cnt += 1.
- Counter width: clog2(DEBOUNCE_CYCLES+1). cnt never exceeds DEBOUNCE_CYCLES-1.
- Latency:
  - Let edge 0 be the first edge at which btn_in is sampled at its new, steady value.
  - btn_level is updated at edge DEBOUNCE_CYCLES+1.
  - With DEBOUNCE_CYCLES=4, btn_level changes at edge 5.
- Pulses:
  - btn_press[i] and btn_release[i] are registered at the same edge btn_level[i] updates.
  - Each is high for exactly one cycle, then cleared.
  - press and release are never high together on one lane.
- Bounce handling:
  - Any glitch shorter than DEBOUNCE_CYCLES consecutive synchronised cycles produces no output change and no pulse.
  - After a bounce, counting restarts from zero.
- Simultaneous events: several lanes may flip or pulse in the same cycle, each independently.
- Reset mid-operation:
  - Counts in progress are lost.
  - If a button is still held after reset deasserts, it is re-debounced from btn_level=0. A fresh btn_press then fires at the normal latency, measured from the first post-reset sampling edge.
- Reset while btn_level=1 produces no release pulse.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined:
  - Each lane has a hold counter, cleared whenever btn_level is 0 and at the press edge.
  - While btn_level stays 1, btn_press pulses once REPEAT_DELAY cycles after the press pulse, then every REPEAT_PERIOD cycles until release.
  - Repeat pulses are one cycle wide.
  - Release clears the hold counter, and no repeat pulse may coincide with the release pulse.
  - Hold counter width: clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1).
- Undefined:
  - No hold counters are synthesised.
  - btn_press fires only on debounced 0->1 changes.
  - REPEAT_* parameters are ignored.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3):
- Clean press: btn_in[0] 0->1, held, first sampled at edge 0 -> btn_level[0]=1 and btn_press[0]=1 at edge 5; btn_press[0]=0 at edge 6; other lanes stay 0.
- Bounce rejection: btn_in[1] toggles 1,0,1,0 at 2-cycle intervals then returns to 0 -> btn_level[1], btn_press[1] and btn_release[1] never assert.
- Release: lane 2 debounced high, btn_in[2] drops, first sampled at edge 0 -> btn_level[2]=0 and btn_release[2]=1 at edge 5 for one cycle.
- Simultaneous: btn_in=4'b1111 at edge 0 -> btn_level=4'b1111 and btn_press=4'b1111 at edge 5, all for one cycle.
- Reset mid-hold: lane 3 debounced high, reset=1 for one edge while btn_in[3] stays 1 -> outputs 0 after the reset edge with no release pulse; btn_press[3] re-fires at the normal latency (edge 5) counting from the first post-reset sampling edge.
- Auto-repeat, macro defined: hold btn_in[0] -> press pulse at edge 5, repeats at edges 15, 18, 21, and so on; after release, no further press pulses.
